arb_mux2_ctrl: RTL and testbench

- Sequencing controller for a 2:1 select datapath: arbitrates two valid/ready requesters (A, B) onto one registered output channel.
- Drives select `o_sel` (1 = A, 0 = B), which is never X after reset.
- Bounded-burst round-robin: the current owner keeps the channel until it idles or reaches MAX_BURST consecutive transfers while the other side waits.
- Sits between producer blocks and a shared consumer.

---
 rtl/arb_mux2_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_arb_mux2_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux2_ctrl.sv
// arb_mux2_ctrl
//   Bounded-burst round-robin arbiter for two valid/ready requesters (A, B)
//   feeding one registered output channel. The current owner keeps the
//   channel until it idles or, while the other side waits, until it has
//   made MAX_BURST consecutive transfers.
//
// Parameters
//   W          data width
//   MAX_BURST  consecutive transfers per owner while the other side is valid (1..15)
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_a_valid/o_a_ready/i_a_data   requester A handshake and data
//   i_b_valid/o_b_ready/i_b_data   requester B handshake and data
//   o_valid/i_ready/o_data  registered output channel
//   o_sel                   source of o_data: 1 = A, 0 = B
//   o_owner                 FSM state: 0 IDLE, 1 OWN_A, 2 OWN_B
//
// Optional build macro
//   ARB_MUX2_ASSERT_EN      compiles the embedded protocol/X checks

module arb_mux2_ctrl #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_a_valid,
    output logic         o_a_ready,
    input  logic [W-1:0] i_a_data,
    input  logic         i_b_valid,
    output logic         o_b_ready,
    input  logic [W-1:0] i_b_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_sel,
    output logic [1:0]   o_owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       load_en;
    logic       gnt_a, gnt_b;

    // Output register is free when empty or being drained this cycle.
    assign load_en = !o_valid | i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        if (load_en) begin
            unique case (state)
                IDLE: begin
                    if (i_a_valid) begin
                        gnt_a     = 1'b1;
                        state_nxt = OWN_A;
                        cnt_nxt   = 4'd1;
                    end else if (i_b_valid) begin
                        gnt_b     = 1'b1;
                        state_nxt = OWN_B;
                        cnt_nxt   = 4'd1;
                    end
                end
                OWN_A: begin
                    // Burst limit only matters when B is actually waiting.
                    if (i_a_valid && (!i_b_valid || cnt < MAX_B)) begin
                        gnt_a   = 1'b1;
                        cnt_nxt = (cnt == 4'hF) ? cnt : cnt + 4'd1;
                    end else if (i_b_valid) begin
                        gnt_b     = 1'b1;
                        state_nxt = OWN_B;
                        cnt_nxt   = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
                OWN_B: begin
                    if (i_b_valid && (!i_a_valid || cnt < MAX_B)) begin
                        gnt_b   = 1'b1;
                        cnt_nxt = (cnt == 4'hF) ? cnt : cnt + 4'd1;
                    end else if (i_a_valid) begin
                        gnt_a     = 1'b1;
                        state_nxt = OWN_A;
                        cnt_nxt   = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign o_a_ready = load_en & gnt_a;
    assign o_b_ready = load_en & gnt_b;
    assign o_owner   = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= 1'b0;
        end else if (load_en) begin
            if (gnt_a | gnt_b) begin
                o_valid <= 1'b1;
                o_data  <= gnt_a ? i_a_data : i_b_data;
                o_sel   <= gnt_a;
            end else begin
                // Nothing granted: drop valid, keep last data/sel visible.
                o_valid <= 1'b0;
            end
        end
    end

`ifdef ARB_MUX2_ASSERT_EN
    always_comb begin
        if (i_rst_n) begin
            assert final (^{o_sel, o_valid, o_owner} !== 1'bx)
                else $error("o_sel/o_valid/o_owner unknown after reset");
        end
        assert final (!(o_a_ready & o_b_ready))
            else $error("o_a_ready and o_b_ready both asserted");
        assert final (!o_a_ready || i_a_valid)
            else $error("o_a_ready without i_a_valid");
        assert final (!o_b_ready || i_b_valid)
            else $error("o_b_ready without i_b_valid");
        assert final (o_owner != 2'd3)
            else $error("o_owner illegal encoding 3");
    end

    // Remember the pre-edge output and whether it was stalled, then check
    // that a stalled output did not move across the edge.
    logic         stall_q;
    logic [W-1:0] data_q;
    logic         sel_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            stall_q <= o_valid & !i_ready;
            data_q  <= o_data;
            sel_q   <= o_sel;
        end
    end

    always_comb begin
        if (i_rst_n && stall_q) begin
            assert final ({o_data, o_sel} === {data_q, sel_q})
                else $error("o_data/o_sel changed during output stall");
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux2_ctrl.sv
// tb_arb_mux2_ctrl
//   Directed bench for arb_mux2_ctrl. Instance u_dut0 uses MAX_BURST=4,
//   u_dut1 uses MAX_BURST=1; both share the requester-side inputs.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_arb_mux2_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, ready;
    logic [7:0] a_data, b_data;

    logic       a_rdy0, b_rdy0, vld0, sel0;
    logic [7:0] data0;
    logic [1:0] own0;
    logic       a_rdy1, b_rdy1, vld1, sel1;
    logic [7:0] data1;
    logic [1:0] own1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_mux2_ctrl #(.W(8), .MAX_BURST(4)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_valid(a_valid), .o_a_ready(a_rdy0), .i_a_data(a_data),
        .i_b_valid(b_valid), .o_b_ready(b_rdy0), .i_b_data(b_data),
        .o_valid(vld0), .i_ready(ready), .o_data(data0),
        .o_sel(sel0), .o_owner(own0)
    );

    arb_mux2_ctrl #(.W(8), .MAX_BURST(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_valid(a_valid), .o_a_ready(a_rdy1), .i_a_data(a_data),
        .i_b_valid(b_valid), .o_b_ready(b_rdy1), .i_b_data(b_data),
        .o_valid(vld1), .i_ready(ready), .o_data(data1),
        .o_sel(sel1), .o_owner(own1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
        ready   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'($urandom);
            b_valid = 1'($urandom);
            ready   = 1'($urandom);
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
            tick();
        end
        checks++;
        if ({vld0, sel0, data0, own0} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: valid=%b sel=%b data=%h owner=%0d, want 0/0/00/0",
                     vld0, sel0, data0, own0);
        end
        rst_n   = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'h3C;
        b_valid = 1'b0;
        ready   = 1'b1;
        tick();
        checks++;
        if ({vld0, data0, sel0} !== {1'b1, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL first_xfer: valid=%b data=%h sel=%b, want 1/3c/1", vld0, data0, sel0);
        end
        idle_inputs();
        tick();
        checks++;
        if ({vld0, own0} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL drop_to_idle: valid=%b owner=%0d, want 0/0", vld0, own0);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_d [12];
        logic [7:0] ka, kb;
        logic       ra, rb;
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                  8'hA4, 8'hA5, 8'hA6, 8'hA7};
        ka = 8'd0;
        kb = 8'd0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        ready   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_data = 8'hA0 + ka;
            b_data = 8'hB0 + kb;
            #1;
            ra = a_rdy0;
            rb = b_rdy0;
            tick();
            if (ra) ka++;
            if (rb) kb++;
            checks++;
            if ({vld0, data0, sel0} !== {1'b1, exp_d[i], exp_d[i][7:4] == 4'hA}) begin
                errors++;
                $display("FAIL burst[%0d]: valid=%b data=%h sel=%b, want 1/%h/%b",
                         i, vld0, data0, sel0, exp_d[i], exp_d[i][7:4] == 4'hA);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_lone();
        int         nx;
        logic [7:0] kb;
        nx = 0;
        kb = 8'd0;
        b_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b_data = 8'hC0 + kb;
            #1;
            if (b_rdy0) begin
                nx++;
                kb++;
            end
            tick();
        end
        checks++;
        if (nx !== 20 || {vld0, data0, sel0, own0} !== {1'b1, 8'hD3, 1'b0, 2'd2}) begin
            errors++;
            $display("FAIL lone_b: xfers=%0d valid=%b data=%h sel=%b owner=%0d, want 20/1/d3/0/2",
                     nx, vld0, data0, sel0, own0);
        end
        checks++;
        if (u_dut0.cnt !== 4'd15) begin
            errors++;
            $display("FAIL cnt_saturate: cnt=%0d, want 15", u_dut0.cnt);
        end
        b_valid = 1'b0;
        tick();
        checks++;
        if ({vld0, own0} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL lone_drop: valid=%b owner=%0d, want 0/0", vld0, own0);
        end
    endtask

    task automatic test_backpressure();
        a_valid = 1'b1;
        a_data  = 8'h55;
        ready   = 1'b1;
        tick();
        a_data  = 8'h56;
        b_valid = 1'b1;
        b_data  = 8'h66;
        ready   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({a_rdy0, b_rdy0} !== 2'b00) begin
                errors++;
                $display("FAIL stall_ready[%0d]: a_ready=%b b_ready=%b, want 0/0", i, a_rdy0, b_rdy0);
            end
            tick();
            checks++;
            if ({vld0, data0, sel0, own0} !== {1'b1, 8'h55, 1'b1, 2'd1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h sel=%b owner=%0d, want 1/55/1/1",
                         i, vld0, data0, sel0, own0);
            end
        end
        ready = 1'b1;
        #1;
        checks++;
        if ({a_rdy0, b_rdy0} !== 2'b10) begin
            errors++;
            $display("FAIL resume_ready: a_ready=%b b_ready=%b, want 1/0", a_rdy0, b_rdy0);
        end
        tick();
        checks++;
        if ({vld0, data0, sel0} !== {1'b1, 8'h56, 1'b1}) begin
            errors++;
            $display("FAIL resume_data: valid=%b data=%h sel=%b, want 1/56/1", vld0, data0, sel0);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_alternation();
        logic [7:0] exp_d [6];
        logic [7:0] ka, kb;
        logic       ra, rb;
        exp_d = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        ka = 8'd0;
        kb = 8'd0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        ready   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 8'h10 + ka;
            b_data = 8'h20 + kb;
            #1;
            ra = a_rdy1;
            rb = b_rdy1;
            tick();
            if (ra) ka++;
            if (rb) kb++;
            checks++;
            if ({vld1, data1, sel1} !== {1'b1, exp_d[i], (i % 2) == 0}) begin
                errors++;
                $display("FAIL alternate[%0d]: valid=%b data=%h sel=%b, want 1/%h/%b",
                         i, vld1, data1, sel1, exp_d[i], (i % 2) == 0);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        b_valid = 1'b1;
        b_data  = 8'h77;
        ready   = 1'b1;
        tick();
        tick();
        checks++;
        if ({vld0, own0, sel0} !== {1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL pre_reset: valid=%b owner=%0d sel=%b, want 1/2/0", vld0, own0, sel0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vld0, sel0, data0, own0, u_dut0.cnt} !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: valid=%b sel=%b data=%h owner=%0d cnt=%0d, want all 0",
                     vld0, sel0, data0, own0, u_dut0.cnt);
        end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({vld0, own0} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL post_reset: valid=%b owner=%0d, want 0/0", vld0, own0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        ready   = 1'b0;
        a_data  = 8'h00;
        b_data  = 8'h00;
        #2;
        test_reset();
        test_burst();
        test_lone();
        test_backpressure();
        test_alternation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
